// File: rtl/ball_motion.sv
// Ball physics engine: launches balls from the paddle and steps every ball once per frame tick.
// A frame walks the balls serially, one STEP and one COMMIT cycle per ball, then one DONE cycle.
module ball_motion #(
  parameter int unsigned BALL_NUM = 2,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned SPEED    = 2,
  parameter int unsigned PADDLE_Y = 440,
  parameter int unsigned START_Y  = 400
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_tick,
  input  logic                    launch,
  input  logic [9:0]              paddle_x,
  input  logic [5:0]              paddle_half,
  input  logic [5:0]              radius,
  output logic [BALL_NUM*10-1:0]  xs,
  output logic [BALL_NUM*10-1:0]  ys,
  output logic [BALL_NUM-1:0]     active,
  output logic                    busy,
  output logic                    ball_lost,
  output logic                    all_lost
);

  localparam int unsigned IdxW = (BALL_NUM > 1) ? $clog2(BALL_NUM) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BALL_NUM - 1);

  localparam logic signed [11:0] Spd  = 12'(SPEED);
  localparam logic signed [11:0] WMax = 12'(SCREEN_W - 1);
  localparam logic signed [11:0] HMax = 12'(SCREEN_H - 1);
  localparam logic signed [11:0] PadY = 12'(PADDLE_Y);
  localparam logic [9:0]         CenX = 10'(SCREEN_W / 2);
  localparam logic [9:0]         StY  = 10'(START_Y);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStep   = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;

  // Velocity is stored as a sign per axis; magnitude is always SPEED.
  logic [9:0]          x_q   [BALL_NUM];
  logic [9:0]          y_q   [BALL_NUM];
  logic                vxn_q [BALL_NUM];
  logic                vyn_q [BALL_NUM];
  logic [BALL_NUM-1:0] active_q;
  logic [BALL_NUM-1:0] act_tick_q;

  logic [9:0]          stage_x_q, stage_y_q;
  logic                stage_vxn_q, stage_vyn_q, stage_lost_q;
  logic                ball_lost_q;

  logic                free_found;
  logic [IdxW-1:0]     free_idx;

  logic [9:0]          cur_x, cur_y;
  logic                cur_vxn, cur_vyn;
  logic signed [11:0]  rad, px, half, cy, step_vx, step_vy, nx, ny, dx;
  logic                nvxn, nvyn, lost;

  // Lowest-index inactive ball receives the next launch.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = BALL_NUM - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  assign cur_x   = x_q[idx_q];
  assign cur_y   = y_q[idx_q];
  assign cur_vxn = vxn_q[idx_q];
  assign cur_vyn = vyn_q[idx_q];

  // One ball step; later checks see the results of earlier clamps.
  always_comb begin
    rad     = {6'd0, radius};
    px      = {2'd0, paddle_x};
    half    = {6'd0, paddle_half};
    cy      = {2'd0, cur_y};
    step_vx = cur_vxn ? -Spd : Spd;
    step_vy = cur_vyn ? -Spd : Spd;
    nx      = $signed({2'd0, cur_x}) + step_vx;
    ny      = cy + step_vy;
    nvxn    = cur_vxn;
    nvyn    = cur_vyn;
    lost    = 1'b0;
    if (nx < rad) begin
      nx   = rad;
      nvxn = 1'b0;
    end
    if (nx + rad > WMax) begin
      nx   = WMax - rad;
      nvxn = 1'b1;
    end
    if (ny < rad) begin
      ny   = rad;
      nvyn = 1'b0;
    end
    dx = nx - px;
    if (dx[11]) begin
      dx = -dx;
    end
    if (!cur_vyn && (cy + rad < PadY) && (ny + rad >= PadY) && (dx <= half)) begin
      ny   = PadY - rad;
      nvyn = 1'b1;
    end
    if (ny - rad > HMax) begin
      lost = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (frame_tick) begin
          state_d = StStep;
          idx_d   = '0;
        end
      end
      StStep:   state_d = StCommit;
      StCommit: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          state_d = StStep;
          idx_d   = idx_q + IdxW'(1);
        end
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BALL_NUM; i++) begin
        x_q[i]   <= CenX;
        y_q[i]   <= StY;
        vxn_q[i] <= 1'b0;
        vyn_q[i] <= 1'b1;
      end
      active_q     <= '0;
      act_tick_q   <= '0;
      stage_x_q    <= '0;
      stage_y_q    <= '0;
      stage_vxn_q  <= 1'b0;
      stage_vyn_q  <= 1'b0;
      stage_lost_q <= 1'b0;
      ball_lost_q  <= 1'b0;
    end else begin
      ball_lost_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (frame_tick) begin
            act_tick_q <= active_q;
          end else if (launch && free_found) begin
            x_q[free_idx]      <= paddle_x;
            y_q[free_idx]      <= StY;
            vxn_q[free_idx]    <= 1'b0;
            vyn_q[free_idx]    <= 1'b1;
            active_q[free_idx] <= 1'b1;
          end
        end
        StStep: begin
          stage_x_q    <= nx[9:0];
          stage_y_q    <= ny[9:0];
          stage_vxn_q  <= nvxn;
          stage_vyn_q  <= nvyn;
          stage_lost_q <= lost;
        end
        StCommit: begin
          if (active_q[idx_q]) begin
            x_q[idx_q]   <= stage_x_q;
            y_q[idx_q]   <= stage_y_q;
            vxn_q[idx_q] <= stage_vxn_q;
            vyn_q[idx_q] <= stage_vyn_q;
            if (stage_lost_q) begin
              active_q[idx_q] <= 1'b0;
              ball_lost_q     <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    xs = '0;
    ys = '0;
    for (int i = 0; i < BALL_NUM; i++) begin
      xs[i*10 +: 10] = x_q[i];
      ys[i*10 +: 10] = y_q[i];
    end
  end

  assign active    = active_q;
  assign busy      = (state_q != StIdle);
  assign ball_lost = ball_lost_q;
  assign all_lost  = (state_q == StDone) && (|act_tick_q) && !(|active_q);

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: vector table for launch/frame ordering plus hand-built
// multi-frame runs for the wall, paddle and loss cases.
module tb_ball_motion;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        launch = 1'b0;
  logic [9:0]  paddle_x = 10'd0;
  logic [5:0]  paddle_half = 6'd20;
  logic [5:0]  radius = 6'd4;
  logic [19:0] xs, ys;
  logic [1:0]  active;
  logic        busy, ball_lost, all_lost;

  int checks = 0;
  int errors = 0;
  int busy_cnt, bl_cnt, al_cnt;

  ball_motion dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .launch     (launch),
    .paddle_x   (paddle_x),
    .paddle_half(paddle_half),
    .radius     (radius),
    .xs         (xs),
    .ys         (ys),
    .active     (active),
    .busy       (busy),
    .ball_lost  (ball_lost),
    .all_lost   (all_lost)
  );

  always #5 clk = ~clk;

  // op: 0 launch, 1 frame, 2 launch and frame_tick together
  typedef struct {
    int op;
    int px;
    int act;
    int x0, y0, x1, y1;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int bx(input int i);
    return int'(xs[i*10 +: 10]);
  endfunction

  function automatic int by(input int i);
    return int'(ys[i*10 +: 10]);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    frame_tick = 1'b0;
    launch = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_launch(input int px);
    paddle_x = 10'(px);
    launch = 1'b1;
    @(negedge clk);
    launch = 1'b0;
  endtask

  // Runs one frame from IDLE and tallies busy cycles and pulses; bounded wait.
  task automatic run_frame(input bit with_launch, input bit launch_busy);
    frame_tick = 1'b1;
    launch = with_launch;
    @(negedge clk);
    frame_tick = 1'b0;
    launch = launch_busy;
    busy_cnt = 0;
    bl_cnt = 0;
    al_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (!busy) break;
      busy_cnt++;
      bl_cnt += int'(ball_lost);
      al_cnt += int'(all_lost);
      @(negedge clk);
      launch = 1'b0;
    end
    launch = 1'b0;
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) run_frame(1'b0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{op: 0, px: 100, act: 1, x0: 100, y0: 400, x1: 320, y1: 400};
    vecs[1] = '{op: 1, px: 100, act: 1, x0: 102, y0: 398, x1: 320, y1: 400};
    vecs[2] = '{op: 2, px: 200, act: 1, x0: 104, y0: 396, x1: 320, y1: 400};
    vecs[3] = '{op: 0, px: 50,  act: 3, x0: 104, y0: 396, x1: 50,  y1: 400};
    vecs[4] = '{op: 1, px: 50,  act: 3, x0: 106, y0: 394, x1: 52,  y1: 398};
    vecs[5] = '{op: 0, px: 300, act: 3, x0: 106, y0: 394, x1: 52,  y1: 398};

    do_reset();
    check("reset_x0", bx(0), 320);
    check("reset_x1", bx(1), 320);
    check("reset_y0", by(0), 400);
    check("reset_y1", by(1), 400);
    check("reset_active", int'(active), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_ball_lost", int'(ball_lost), 0);
    check("reset_all_lost", int'(all_lost), 0);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].op == 0) begin
        do_launch(vecs[v].px);
      end else begin
        paddle_x = 10'(vecs[v].px);
        run_frame(vecs[v].op == 2, 1'b0);
        check($sformatf("vec%0d_busy_cycles", v), busy_cnt, 5);
        check($sformatf("vec%0d_ball_lost", v), bl_cnt, 0);
      end
      check($sformatf("vec%0d_active", v), int'(active), vecs[v].act);
      check($sformatf("vec%0d_x0", v), bx(0), vecs[v].x0);
      check($sformatf("vec%0d_y0", v), by(0), vecs[v].y0);
      check($sformatf("vec%0d_x1", v), bx(1), vecs[v].x1);
      check($sformatf("vec%0d_y1", v), by(1), vecs[v].y1);
    end

    // Launch while busy must be ignored.
    do_reset();
    do_launch(100);
    run_frame(1'b0, 1'b1);
    check("busy_launch_active", int'(active), 1);
    check("busy_launch_x1", bx(1), 320);
    check("busy_launch_x0", bx(0), 102);

    // Right wall.
    do_reset();
    do_launch(630);
    run_frame(1'b0, 1'b0);
    check("right_x_t1", bx(0), 632);
    run_frame(1'b0, 1'b0);
    check("right_x_t2", bx(0), 634);
    run_frame(1'b0, 1'b0);
    check("right_x_t3_clamp", bx(0), 635);
    run_frame(1'b0, 1'b0);
    check("right_x_t4", bx(0), 633);
    check("right_y_t4", by(0), 392);

    // Top wall, then paddle hit on the way down.
    do_reset();
    do_launch(100);
    paddle_x = 10'd341;
    run_n(198);
    check("top_y_t198", by(0), 4);
    run_n(1);
    check("top_y_t199", by(0), 4);
    run_n(1);
    check("top_y_t200", by(0), 6);
    check("top_x_t200", bx(0), 500);
    run_n(214);
    check("pad_y_t414", by(0), 434);
    run_n(1);
    check("pad_y_t415", by(0), 436);
    check("pad_x_t415", bx(0), 341);
    run_n(1);
    check("pad_y_t416_up", by(0), 434);
    check("pad_active", int'(active), 1);

    // Paddle 100 px away: ball falls through and is lost.
    do_reset();
    do_launch(100);
    paddle_x = 10'd241;
    run_n(415);
    check("miss_y_t415", by(0), 436);
    run_n(1);
    check("miss_y_t416", by(0), 438);
    run_n(22);
    check("miss_y_t438", by(0), 482);
    check("miss_active_t438", int'(active), 1);
    check("miss_no_lost_t438", bl_cnt, 0);
    run_n(1);
    check("lost_active", int'(active), 0);
    check("lost_ball_lost_pulses", bl_cnt, 1);
    check("lost_all_lost_pulses", al_cnt, 1);
    check("lost_y", by(0), 484);
    check("lost_x", bx(0), 293);
    run_n(1);
    check("after_lost_no_pulse", bl_cnt + al_cnt, 0);
    check("after_lost_y_frozen", by(0), 484);

    // Two launches fill both slots; a third is ignored.
    do_reset();
    do_launch(10);
    do_launch(20);
    do_launch(30);
    check("third_launch_active", int'(active), 3);
    check("third_launch_x0", bx(0), 10);
    check("third_launch_x1", bx(1), 20);

    // Reset mid-frame discards the partial frame.
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_active", int'(active), 0);
    check("midrst_x0", bx(0), 320);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(1'b0, 1'b0);
    check("midrst_frame_busy", busy_cnt, 5);
    check("midrst_frame_all_lost", al_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
